// File: rtl/bcd_to_bin.sv
// rtl/bcd_to_bin.sv - sequential packed-BCD to binary converter (reverse double-dabble)
module bcd_to_bin #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET_N,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state_q, state_d;
    logic [BCD_W-1:0]   bcd_r, bcd_d;
    logic [BIN_W-1:0]   bin_r, bin_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [BIN_W-1:0]   bin_out_d;
    logic               busy_d, done_d, err_d;

    logic                     bad_digit;
    logic [BCD_W+BIN_W-1:0]   shifted;
    logic [BCD_W-1:0]         sh_bcd;
    logic [BIN_W-1:0]         sh_bin;

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    // One reverse-dabble step: shift right, then pull each digit >= 8 back by 3.
    always_comb begin
        shifted = {bcd_r, bin_r} >> 1;
        sh_bcd  = shifted[BCD_W+BIN_W-1:BIN_W];
        sh_bin  = shifted[BIN_W-1:0];
        for (int i = 0; i < DIGITS; i++) begin
            if (sh_bcd[4*i+3]) begin
                sh_bcd[4*i +: 4] = sh_bcd[4*i +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        bcd_d     = bcd_r;
        bin_d     = bin_r;
        cnt_d     = cnt;
        bin_out_d = bin_out;
        busy_d    = busy;
        done_d    = 1'b0;
        err_d     = err;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (bad_digit) begin
                        bin_out_d = '0;
                        err_d     = 1'b1;
                        done_d    = 1'b1;
                    end else begin
                        bcd_d   = bcd_in;
                        bin_d   = '0;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        err_d   = 1'b0;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                bcd_d = sh_bcd;
                bin_d = sh_bin;
                cnt_d = cnt + 1'b1;
                if (cnt == CNT_W'(BIN_W - 1)) begin
                    bin_out_d = sh_bin;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            bcd_r   <= '0;
            bin_r   <= '0;
            cnt     <= '0;
            bin_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_r   <= bcd_d;
            bin_r   <= bin_d;
            cnt     <= cnt_d;
            bin_out <= bin_out_d;
            busy    <= busy_d;
            done    <= done_d;
            err     <= err_d;
        end
    end

endmodule
